// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer capture controller:
// acquisition state encoding and default bus widths.
package la_pkg;

   localparam int LA_ADDR_W = 10;
   localparam int LA_DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRE_FILL  = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_DONE      = 3'd4,
      ST_READ      = 3'd5
   } la_state_t;

endpackage

// File: rtl/la_ring_ptr.sv
// Modulo-2**ADDR_W ring pointer: clear, load of (base - offset), or increment.
// Arithmetic wraps naturally at the register width.
module la_ring_ptr #(
   parameter int ADDR_W = 4
)(
   input  logic              CLK,
   input  logic              RST,
   input  logic              i_clr,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_base,
   input  logic [ADDR_W-1:0] i_off,
   input  logic              i_inc,
   output logic [ADDR_W-1:0] o_ptr
);

   logic [ADDR_W-1:0] r_ptr;

   always_ff @(posedge CLK) begin
      if (RST || i_clr) begin
         r_ptr <= '0;
      end else if (i_load) begin
         r_ptr <= i_base - i_off;
      end else if (i_inc) begin
         r_ptr <= r_ptr + ADDR_W'(1);
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture window controller: pre-trigger ring fill, trigger arm, post-trigger
// count, then chronological readout addressing for the host.
module la_capture_ctrl
   import la_pkg::*;
#(
   parameter int ADDR_W = LA_ADDR_W,
   parameter int DATA_W = LA_DATA_W
)(
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              ABORT,
   input  logic              SAMPLE_EN,
   input  logic [DATA_W-1:0] DATA_IN,
   input  logic              TRIG_IN,
   input  logic              FORCE_TRIG,
   input  logic [ADDR_W-1:0] PRETRIG_LEN,
   input  logic              RD_NEXT,
   output logic              WR_EN,
   output logic [ADDR_W-1:0] WR_ADDR,
   output logic [DATA_W-1:0] WR_DATA,
   output logic [ADDR_W-1:0] RD_ADDR,
   output logic [ADDR_W-1:0] TRIG_ADDR,
   output logic              BUSY,
   output logic              DONE,
   output logic              RD_LAST
);

   localparam logic [ADDR_W-1:0] LAST_IDX = '1;

   la_state_t         r_state;
   logic [ADDR_W-1:0] r_pre;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] r_rd_cnt;
   logic [ADDR_W-1:0] r_trig_addr;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_wr_en;
   logic              r_busy;
   logic              r_done;
   logic              r_rd_last;

   logic [ADDR_W-1:0] w_wr_ptr;
   logic [ADDR_W-1:0] w_rd_ptr;
   logic [ADDR_W-1:0] w_post_init;
   logic [ADDR_W-1:0] w_done_base;
   logic              w_busy_st;
   logic              w_sample;
   logic              w_trig;
   logic              w_trig_evt;
   logic              w_start_ok;
   logic              w_enter_done;
   logic              w_rd_step;

   always_comb begin
      w_busy_st    = (r_state == ST_PRE_FILL) || (r_state == ST_WAIT_TRIG) ||
                     (r_state == ST_POST);
      w_sample     = SAMPLE_EN && w_busy_st;
      w_trig       = SAMPLE_EN && (TRIG_IN || FORCE_TRIG);
      w_trig_evt   = (r_state == ST_WAIT_TRIG) && w_trig;
      w_post_init  = LAST_IDX - r_pre;
      w_start_ok   = (r_state == ST_IDLE) && START;
      w_enter_done = (w_trig_evt && (w_post_init == '0)) ||
                     ((r_state == ST_POST) && SAMPLE_EN && (r_cnt == ADDR_W'(1)));
      // With no post samples the trigger address is still the live write pointer.
      w_done_base  = (r_state == ST_WAIT_TRIG) ? w_wr_ptr : r_trig_addr;
      w_rd_step    = (r_state == ST_READ) && RD_NEXT && !r_rd_last;
   end

   la_ring_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
      .CLK    (CLK),
      .RST    (RST),
      .i_clr  (ABORT || w_start_ok),
      .i_load (1'b0),
      .i_base ('0),
      .i_off  ('0),
      .i_inc  (w_sample),
      .o_ptr  (w_wr_ptr)
   );

   la_ring_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
      .CLK    (CLK),
      .RST    (RST),
      .i_clr  (ABORT),
      .i_load (w_enter_done),
      .i_base (w_done_base),
      .i_off  (r_pre),
      .i_inc  (w_rd_step),
      .o_ptr  (w_rd_ptr)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_pre       <= '0;
         r_cnt       <= '0;
         r_rd_cnt    <= '0;
         r_trig_addr <= '0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_wr_en     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_rd_last   <= 1'b0;
      end else if (ABORT) begin
         r_state   <= ST_IDLE;
         r_pre     <= '0;
         r_cnt     <= '0;
         r_rd_cnt  <= '0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_wr_en   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_rd_last <= 1'b0;
      end else begin
         r_wr_en <= w_sample;
         if (w_sample) begin
            r_wr_addr <= w_wr_ptr;
            r_wr_data <= DATA_IN;
         end
         case (r_state)
            ST_IDLE: begin
               // PRETRIG_LEN is ADDR_W wide, so it can never exceed DEPTH-1.
               if (START) begin
                  r_pre   <= PRETRIG_LEN;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= (PRETRIG_LEN == '0) ? ST_WAIT_TRIG : ST_PRE_FILL;
               end
            end
            ST_PRE_FILL: begin
               if (SAMPLE_EN) begin
                  r_cnt <= r_cnt + ADDR_W'(1);
                  if (r_cnt + ADDR_W'(1) == r_pre) begin
                     r_state <= ST_WAIT_TRIG;
                  end
               end
            end
            ST_WAIT_TRIG: begin
               if (w_trig) begin
                  r_trig_addr <= w_wr_ptr;
                  r_cnt       <= w_post_init;
                  if (w_post_init == '0) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_POST;
                  end
               end
            end
            ST_POST: begin
               if (SAMPLE_EN) begin
                  r_cnt <= r_cnt - ADDR_W'(1);
                  if (r_cnt == ADDR_W'(1)) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               r_state   <= ST_READ;
               r_rd_cnt  <= '0;
               r_rd_last <= 1'b0;
            end
            ST_READ: begin
               if (RD_NEXT) begin
                  if (r_rd_last) begin
                     r_state   <= ST_IDLE;
                     r_done    <= 1'b0;
                     r_rd_last <= 1'b0;
                  end else begin
                     r_rd_cnt  <= r_rd_cnt + ADDR_W'(1);
                     r_rd_last <= (r_rd_cnt + ADDR_W'(1) == LAST_IDX);
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign WR_EN     = r_wr_en;
   assign WR_ADDR   = r_wr_addr;
   assign WR_DATA   = r_wr_data;
   assign RD_ADDR   = w_rd_ptr;
   assign TRIG_ADDR = r_trig_addr;
   assign BUSY      = r_busy;
   assign DONE      = r_done;
   assign RD_LAST   = r_rd_last;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl at DEPTH=16 with a behavioural sample RAM
// fed from the write port and read through RD_ADDR.
module tb_la_capture_ctrl;

   localparam int AW = 4;
   localparam int DW = 8;

   logic          CLK;
   logic          RST;
   logic          START;
   logic          ABORT;
   logic          SAMPLE_EN;
   logic [DW-1:0] DATA_IN;
   logic          TRIG_IN;
   logic          FORCE_TRIG;
   logic [AW-1:0] PRETRIG_LEN;
   logic          RD_NEXT;
   logic          WR_EN;
   logic [AW-1:0] WR_ADDR;
   logic [DW-1:0] WR_DATA;
   logic [AW-1:0] RD_ADDR;
   logic [AW-1:0] TRIG_ADDR;
   logic          BUSY;
   logic          DONE;
   logic          RD_LAST;

   logic [DW-1:0] mem [16];
   int            n_checks = 0;
   int            n_err    = 0;

   la_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .START       (START),
      .ABORT       (ABORT),
      .SAMPLE_EN   (SAMPLE_EN),
      .DATA_IN     (DATA_IN),
      .TRIG_IN     (TRIG_IN),
      .FORCE_TRIG  (FORCE_TRIG),
      .PRETRIG_LEN (PRETRIG_LEN),
      .RD_NEXT     (RD_NEXT),
      .WR_EN       (WR_EN),
      .WR_ADDR     (WR_ADDR),
      .WR_DATA     (WR_DATA),
      .RD_ADDR     (RD_ADDR),
      .TRIG_ADDR   (TRIG_ADDR),
      .BUSY        (BUSY),
      .DONE        (DONE),
      .RD_LAST     (RD_LAST)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (WR_EN) mem[WR_ADDR] <= WR_DATA;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic capture_window(input int pre, input int base, input int trig_lo,
                                 input int trig_hi, input int nsamp,
                                 input int exp_trig, input int exp_rd);
      PRETRIG_LEN = AW'(pre);
      START       = 1'b1;
      SAMPLE_EN   = 1'b0;
      TRIG_IN     = (trig_lo == 0);
      tick();
      START = 1'b0;
      chk("busy_after_start", 32'(BUSY), 1);
      for (int s = 0; s < nsamp; s++) begin
         SAMPLE_EN = 1'b1;
         DATA_IN   = DW'(base + s);
         TRIG_IN   = (s >= trig_lo) && (s <= trig_hi);
         tick();
         chk("wr_en", 32'(WR_EN), 1);
         chk("wr_addr", 32'(WR_ADDR), s % 16);
         chk("wr_data", 32'(WR_DATA), (base + s) & 255);
         chk("busy", 32'(BUSY), 32'(s != nsamp - 1));
         chk("done", 32'(DONE), 32'(s == nsamp - 1));
      end
      SAMPLE_EN = 1'b0;
      TRIG_IN   = 1'b0;
      chk("trig_addr", 32'(TRIG_ADDR), exp_trig);
      chk("rd_start", 32'(RD_ADDR), exp_rd);
      chk("rd_last_in_done", 32'(RD_LAST), 0);
      tick();
      chk("wr_en_after_done", 32'(WR_EN), 0);
      chk("done_in_read", 32'(DONE), 1);
   endtask

   task automatic readout(input int exp_rd, input int data0);
      RD_NEXT = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("rd_addr", 32'(RD_ADDR), (exp_rd + i) % 16);
         chk("rd_data", 32'(mem[RD_ADDR]), (data0 + i) & 255);
         chk("rd_last", 32'(RD_LAST), 32'(i == 15));
         tick();
      end
      RD_NEXT = 1'b0;
      chk("done_after_read", 32'(DONE), 0);
      chk("rd_last_after_read", 32'(RD_LAST), 0);
   endtask

   initial begin
      int idx;
      RST         = 1'b1;
      START       = 1'b0;
      ABORT       = 1'b0;
      SAMPLE_EN   = 1'b0;
      DATA_IN     = '0;
      TRIG_IN     = 1'b0;
      FORCE_TRIG  = 1'b0;
      PRETRIG_LEN = '0;
      RD_NEXT     = 1'b0;
      tick();
      tick();
      chk("rst_wr_en", 32'(WR_EN), 0);
      chk("rst_wr_addr", 32'(WR_ADDR), 0);
      chk("rst_wr_data", 32'(WR_DATA), 0);
      chk("rst_rd_addr", 32'(RD_ADDR), 0);
      chk("rst_trig_addr", 32'(TRIG_ADDR), 0);
      chk("rst_busy", 32'(BUSY), 0);
      chk("rst_done", 32'(DONE), 0);
      chk("rst_rd_last", 32'(RD_LAST), 0);
      RST = 1'b0;
      tick();
      $display("step reset: checks=%0d errors=%0d", n_checks, n_err);

      // 1: pre=4, trigger at sample 10, window ends at sample 21
      capture_window(4, 8'h00, 10, 10, 22, 10, 6);
      readout(6, 8'h06);
      $display("step 1 pre=4 trig@10: checks=%0d errors=%0d", n_checks, n_err);

      // 2: trigger held high from START, honoured only once history is full
      capture_window(4, 8'h40, 0, 1000, 16, 4, 0);
      readout(0, 8'h40);
      $display("step 2 pre=4 trig held: checks=%0d errors=%0d", n_checks, n_err);

      // 3: no pre-trigger history, 15 post samples
      capture_window(0, 8'h80, 0, 0, 16, 0, 0);
      readout(0, 8'h80);
      $display("step 3 pre=0: checks=%0d errors=%0d", n_checks, n_err);

      // 4: maximal history, trigger after the ring has wrapped
      capture_window(15, 8'hA0, 40, 40, 41, 8, 9);
      readout(9, 8'hB9);
      $display("step 4 pre=15 wrap: checks=%0d errors=%0d", n_checks, n_err);

      // 5: sparse sampling, TRIG_IN without a sample is ignored, FORCE_TRIG fires
      PRETRIG_LEN = 4'd2;
      START       = 1'b1;
      tick();
      START = 1'b0;
      idx   = 0;
      for (int c = 0; c <= 48; c++) begin
         SAMPLE_EN  = (c % 3 == 0);
         DATA_IN    = DW'(32'h20 + idx);
         TRIG_IN    = (c == 4);
         FORCE_TRIG = (c == 9);
         tick();
         if (SAMPLE_EN) idx++;
         chk("s5_wr_en", 32'(WR_EN), 32'(c % 3 == 0));
         if (c == 4) begin
            chk("s5_trig_ignored", 32'(TRIG_ADDR), 8);
            chk("s5_busy_waiting", 32'(BUSY), 1);
         end
         if (c == 9) chk("s5_force_trig", 32'(TRIG_ADDR), 3);
         if (c == 45) chk("s5_busy_post", 32'(BUSY), 1);
         if (c == 48) begin
            chk("s5_done", 32'(DONE), 1);
            chk("s5_busy_end", 32'(BUSY), 0);
            chk("s5_rd_start", 32'(RD_ADDR), 1);
         end
      end
      SAMPLE_EN  = 1'b0;
      TRIG_IN    = 1'b0;
      FORCE_TRIG = 1'b0;
      tick();
      readout(1, 8'h21);
      $display("step 5 sparse/force: checks=%0d errors=%0d", n_checks, n_err);

      // 6a: ABORT during POST wins over a simultaneous START
      PRETRIG_LEN = 4'd4;
      START       = 1'b1;
      tick();
      START = 1'b0;
      for (int s = 0; s < 8; s++) begin
         SAMPLE_EN = 1'b1;
         DATA_IN   = DW'(32'h60 + s);
         TRIG_IN   = (s == 4);
         tick();
      end
      TRIG_IN = 1'b0;
      chk("s6_busy_post", 32'(BUSY), 1);
      chk("s6_trig_addr", 32'(TRIG_ADDR), 4);
      chk("s6_wr_addr_pre", 32'(WR_ADDR), 7);
      ABORT = 1'b1;
      START = 1'b1;
      tick();
      ABORT = 1'b0;
      START = 1'b0;
      chk("s6_abort_wr_en", 32'(WR_EN), 0);
      chk("s6_abort_busy", 32'(BUSY), 0);
      chk("s6_abort_done", 32'(DONE), 0);
      chk("s6_abort_wr_addr", 32'(WR_ADDR), 0);
      chk("s6_abort_trig_hold", 32'(TRIG_ADDR), 4);
      tick();
      chk("s6_idle_wr_en", 32'(WR_EN), 0);
      chk("s6_idle_busy", 32'(BUSY), 0);
      SAMPLE_EN = 1'b0;
      $display("step 6a abort: checks=%0d errors=%0d", n_checks, n_err);

      // 6b: RST in the middle of READ clears every output
      capture_window(15, 8'hC0, 0, 1000, 16, 15, 0);
      RD_NEXT = 1'b1;
      tick();
      tick();
      tick();
      RD_NEXT = 1'b0;
      chk("s6_rd_addr_mid", 32'(RD_ADDR), 3);
      chk("s6_rd_data_mid", 32'(mem[RD_ADDR]), 8'hC3);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("s6_rst_wr_en", 32'(WR_EN), 0);
      chk("s6_rst_wr_addr", 32'(WR_ADDR), 0);
      chk("s6_rst_wr_data", 32'(WR_DATA), 0);
      chk("s6_rst_rd_addr", 32'(RD_ADDR), 0);
      chk("s6_rst_trig_addr", 32'(TRIG_ADDR), 0);
      chk("s6_rst_busy", 32'(BUSY), 0);
      chk("s6_rst_done", 32'(DONE), 0);
      chk("s6_rst_rd_last", 32'(RD_LAST), 0);
      RD_NEXT = 1'b1;
      tick();
      RD_NEXT = 1'b0;
      chk("s6_rd_next_idle", 32'(RD_ADDR), 0);
      $display("step 6b reset in read: checks=%0d errors=%0d", n_checks, n_err);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
